// File: rtl/tcdm_stream_pkg.sv
// Shared types for the TCDM stream initiator: FSM state encoding and the
// latched command record (running address, remaining words, direction).
package tcdm_stream_pkg;

    localparam int unsigned TcdmAddrWidth = 32;
    localparam int unsigned TcdmLenWidth  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DRAIN
    } state_e;

    // addr and len advance as words are handshaked, so they double as the
    // running address and the remaining-word counter.
    typedef struct packed {
        logic [TcdmAddrWidth-1:0] addr;
        logic [TcdmLenWidth-1:0]  len;
        logic                     write;
    } cmd_t;

endpackage

// File: rtl/tcdm_stream_fifo.sv
// Read-response FIFO: simultaneous push and pop both take effect; flushed
// only by reset. Callers guarantee no push when full and no pop when empty.
module tcdm_stream_fifo #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 4,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntWidth-1:0]  count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned         PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrWidth-1:0]  wptr_q, rptr_q;
    logic [CntWidth-1:0]  cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + PtrWidth'(1);
            if (pop_i)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + PtrWidth'(1);
            cnt_q <= cnt_q + CntWidth'(push_i) - CntWidth'(pop_i);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CntWidth'(Depth));
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/tcdm_stream_initiator.sv
// TCDM initiator: turns (addr, len, dir) commands into req/gnt word transfers,
// buffering 1-cycle-latency read responses in a FIFO and writing from a stream.
module tcdm_stream_initiator
    import tcdm_stream_pkg::*;
#(
    parameter int unsigned AddrWidth = TcdmAddrWidth,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned MasterId  = 0,
    parameter int unsigned LenWidth  = TcdmLenWidth,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [AddrWidth-1:0] cmd_addr_i,
    input  logic [LenWidth-1:0]  cmd_len_i,
    input  logic                 cmd_write_i,
    input  logic                 wdata_valid_i,
    output logic                 wdata_ready_o,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   wbe_i,
    output logic                 rdata_valid_o,
    input  logic                 rdata_ready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [AddrWidth-1:0] tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [DataWidth-1:0] tcdm_data_o,
    output logic [BeWidth-1:0]   tcdm_be_o,
    output logic [IdWidth-1:0]   tcdm_id_o,
    input  logic [DataWidth-1:0] tcdm_r_data_i,
    input  logic [IdWidth-1:0]   tcdm_r_id_i
);

    localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic                 inflight_q;
    logic                 hold_valid_q, hold_valid_d;
    logic [DataWidth-1:0] hold_data_q, hold_data_d;
    logic [BeWidth-1:0]   hold_be_q, hold_be_d;
    logic                 done_q, done_d;

    logic [CntWidth-1:0]  fifo_cnt;
    logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CntWidth:0]    occupancy;
    logic                 credit, handshake, wdata_fire, last_word;

    // Outstanding response counts against FIFO space, so the unconditional
    // push one cycle after a read grant can never overflow.
    assign occupancy = {1'b0, fifo_cnt} + (CntWidth + 1)'(inflight_q);
    assign credit    = occupancy < (CntWidth + 1)'(FifoDepth);
    assign last_word = (cmd_q.len == LenWidth'(1));

    assign tcdm_req_o = ((state_q == RD) && (cmd_q.len != '0) && credit) ||
                        ((state_q == WR) && hold_valid_q);
    assign handshake  = tcdm_req_o && tcdm_gnt_i;

    // A full holding register may refill in the cycle it drains, except when
    // the word draining is the last one the command asked for.
    assign wdata_ready_o = (state_q == WR) && (!hold_valid_q || (tcdm_gnt_i && !last_word));
    assign wdata_fire    = wdata_valid_i && wdata_ready_o;

    assign fifo_push = inflight_q;
    assign fifo_pop  = rdata_valid_o && rdata_ready_i;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        done_d       = 1'b0;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_be_d    = hold_be_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d.addr  = cmd_addr_i & ~AddrWidth'(BeWidth - 1);
                    cmd_d.len   = cmd_len_i;
                    cmd_d.write = cmd_write_i;
                    if (cmd_len_i == '0) done_d  = 1'b1;
                    else                 state_d = cmd_write_i ? WR : RD;
                end
            end
            RD: begin
                if (handshake) begin
                    cmd_d.addr = cmd_q.addr + AddrWidth'(BeWidth);
                    cmd_d.len  = cmd_q.len - LenWidth'(1);
                    if (last_word) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight_q && fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (handshake) begin
                    cmd_d.addr   = cmd_q.addr + AddrWidth'(BeWidth);
                    cmd_d.len    = cmd_q.len - LenWidth'(1);
                    hold_valid_d = 1'b0;
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (wdata_fire) begin
                    hold_valid_d = 1'b1;
                    hold_data_d  = wdata_i;
                    hold_be_d    = wbe_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            inflight_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_be_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            inflight_q   <= handshake && (state_q == RD);
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            hold_be_q    <= hold_be_d;
            done_q       <= done_d;
        end
    end

    tcdm_stream_fifo #(
        .DataWidth(DataWidth),
        .Depth    (FifoDepth),
        .CntWidth (CntWidth)
    ) i_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (fifo_push),
        .data_i (tcdm_r_data_i),
        .pop_i  (fifo_pop),
        .data_o (rdata_o),
        .count_o(fifo_cnt),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign cmd_ready_o   = (state_q == IDLE);
    assign rdata_valid_o = !fifo_empty;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign tcdm_add_o    = cmd_q.addr;
    assign tcdm_wen_o    = !cmd_q.write;
    assign tcdm_data_o   = hold_data_q;
    assign tcdm_be_o     = hold_be_q;
    assign tcdm_id_o     = IdWidth'(MasterId);

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        inflight_q |-> (tcdm_r_id_i == IdWidth'(MasterId)));
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_push |-> !fifo_full);

endmodule

// File: tb/tb_tcdm_stream_initiator.sv
// Directed bench for tcdm_stream_initiator: drives commands, a TCDM responder
// and the write stream cycle by cycle, checking against hand-derived values.
module tb_tcdm_stream_initiator;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rdata_valid, rdata_ready;
    logic [31:0] rdata;
    logic        busy, done;
    logic        req, gnt, wen;
    logic [31:0] add, tdata, r_data;
    logic [3:0]  be;
    logic [0:0]  id, r_id;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr_idx = 0;

    int          hs_cyc[$];
    logic [31:0] hs_addr[$];
    logic [31:0] hs_data[$];
    logic [3:0]  hs_be[$];
    logic        hs_wen[$];
    logic [31:0] rd_log[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_be[$];

    tcdm_stream_initiator dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_len_i    (cmd_len),
        .cmd_write_i  (cmd_write),
        .wdata_valid_i(wdata_valid),
        .wdata_ready_o(wdata_ready),
        .wdata_i      (wdata),
        .wbe_i        (wbe),
        .rdata_valid_o(rdata_valid),
        .rdata_ready_i(rdata_ready),
        .rdata_o      (rdata),
        .busy_o       (busy),
        .done_o       (done),
        .tcdm_req_o   (req),
        .tcdm_gnt_i   (gnt),
        .tcdm_add_o   (add),
        .tcdm_wen_o   (wen),
        .tcdm_data_o  (tdata),
        .tcdm_be_o    (be),
        .tcdm_id_o    (id),
        .tcdm_r_data_i(r_data),
        .tcdm_r_id_i  (r_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // One clock: sample pre-edge activity, then drive the responder and stream.
    task automatic step();
        logic        rd_hs, w_fire;
        logic [31:0] a;
        @(posedge clk);
        rd_hs  = req && gnt && wen;
        w_fire = wdata_valid && wdata_ready;
        a      = add;
        if (rst_n) begin
            if (req && gnt) begin
                hs_cyc.push_back(cyc);
                hs_addr.push_back(add);
                hs_data.push_back(tdata);
                hs_be.push_back(be);
                hs_wen.push_back(wen);
            end
            if (rdata_valid && rdata_ready) rd_log.push_back(rdata);
            if (done) done_cnt++;
            if (w_fire) wr_idx++;
        end
        cyc++;
        #1;
        r_data = rd_hs ? mem_word(a) : 32'hDEAD_BEEF;
        if (wr_idx < wr_data.size()) begin
            wdata_valid = 1'b1;
            wdata       = wr_data[wr_idx];
            wbe         = wr_be[wr_idx];
        end else begin
            wdata_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] len, input logic w);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_write = w;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int base;
        base = done_cnt;
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > base) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic load_stream(input int n);
        wr_idx      = 0;
        wdata_valid = (n > 0);
        wdata       = wr_data[0];
        wbe         = wr_be[0];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if (cmd_ready !== 1'b1 || wen !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_wen: got ready=%b wen=%b, expected 1/1", cmd_ready, wen);
        end
        tests++;
        if (req !== 1'b0 || add !== 32'h0 || tdata !== 32'h0 || be !== 4'h0 || id !== 1'b0) begin
            fails++;
            $display("FAIL reset_tcdm: got req=%b add=%h data=%h be=%h id=%b, expected all 0", req, add, tdata, be, id);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || rdata_valid !== 1'b0 || wdata_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b done=%b rvalid=%b wready=%b, expected 0", busy, done, rdata_valid, wdata_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_read_basic(input logic [31:0] base_a, input string tag);
        int hb, rb, db;
        bit to;
        hb = hs_addr.size();
        rb = rd_log.size();
        db = done_cnt;
        gnt = 1'b1;
        rdata_ready = 1'b1;
        issue(base_a, 16'd4, 1'b0);
        wait_done(60, to);
        repeat (3) step();
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s_timeout: done not seen within 60 cycles", tag);
        end
        tests++;
        if (hs_addr.size() - hb != 4) begin
            fails++;
            $display("FAIL %s_hs_count: got %0d, expected 4", tag, hs_addr.size() - hb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (hs_addr[hb+i] !== base_a + 32'(4*i) || hs_cyc[hb+i] !== hs_cyc[hb] + i || hs_wen[hb+i] !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_addr%0d: got %h cyc+%0d wen=%b, expected %h cyc+%0d wen=1",
                             tag, i, hs_addr[hb+i], hs_cyc[hb+i] - hs_cyc[hb], hs_wen[hb+i], base_a + 32'(4*i), i);
                end
            end
        end
        tests++;
        if (rd_log.size() - rb != 4) begin
            fails++;
            $display("FAIL %s_rd_count: got %0d, expected 4", tag, rd_log.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (rd_log[rb+i] !== mem_word(base_a + 32'(4*i))) begin
                    fails++;
                    $display("FAIL %s_rdata%0d: got %h, expected %h", tag, i, rd_log[rb+i], mem_word(base_a + 32'(4*i)));
                end
            end
        end
        tests++;
        if (done_cnt - db != 1) begin
            fails++;
            $display("FAIL %s_done_pulses: got %0d, expected 1", tag, done_cnt - db);
        end
    endtask

    task automatic test_backpressure();
        int hb, rb;
        bit to;
        hb = hs_addr.size();
        rb = rd_log.size();
        gnt = 1'b1;
        rdata_ready = 1'b0;
        issue(32'h200, 16'd8, 1'b0);
        repeat (8) step();
        tests++;
        if (hs_addr.size() - hb != 4 || req !== 1'b0) begin
            fails++;
            $display("FAIL bp_credit: got %0d handshakes req=%b, expected 4 req=0", hs_addr.size() - hb, req);
        end
        rdata_ready = 1'b1;
        wait_done(80, to);
        tests++;
        if (to || rd_log.size() - rb != 8) begin
            fails++;
            $display("FAIL bp_complete: got timeout=%b words=%0d, expected 0/8", to, rd_log.size() - rb);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (rd_log[rb+i] !== mem_word(32'h200 + 32'(4*i))) begin
                    fails++;
                    $display("FAIL bp_rdata%0d: got %h, expected %h", i, rd_log[rb+i], mem_word(32'h200 + 32'(4*i)));
                end
            end
        end
    endtask

    task automatic test_gnt_stall();
        int hb, rb;
        bit to;
        // Read with word 2 stalled
        hb = hs_addr.size();
        rb = rd_log.size();
        gnt = 1'b1;
        rdata_ready = 1'b1;
        issue(32'h300, 16'd4, 1'b0);
        step();
        step();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (req !== 1'b1 || add !== 32'h308 || wen !== 1'b1) begin
                fails++;
                $display("FAIL rd_stall%0d: got req=%b add=%h wen=%b, expected 1/00000308/1", i, req, add, wen);
            end
            step();
        end
        gnt = 1'b1;
        wait_done(40, to);
        tests++;
        if (to || hs_addr.size() - hb != 4 || rd_log.size() - rb != 4) begin
            fails++;
            $display("FAIL rd_stall_done: got timeout=%b hs=%0d words=%0d, expected 0/4/4", to, hs_addr.size() - hb, rd_log.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (hs_addr[hb+i] !== 32'h300 + 32'(4*i) || rd_log[rb+i] !== mem_word(32'h300 + 32'(4*i))) begin
                    fails++;
                    $display("FAIL rd_stall_word%0d: got add=%h data=%h, expected %h/%h",
                             i, hs_addr[hb+i], rd_log[rb+i], 32'h300 + 32'(4*i), mem_word(32'h300 + 32'(4*i)));
                end
            end
        end

        // Write with word 2 stalled; a fifth stream word must stay unaccepted
        wr_data = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 32'h5555_0004};
        wr_be   = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        load_stream(5);
        hb = hs_addr.size();
        issue(32'h80, 16'd4, 1'b1);
        step();
        step();
        step();
        gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (req !== 1'b1 || add !== 32'h88 || tdata !== 32'h3333_0002 || be !== 4'hF || wen !== 1'b0) begin
                fails++;
                $display("FAIL wr_stall%0d: got req=%b add=%h data=%h be=%h wen=%b, expected 1/00000088/33330002/f/0",
                         i, req, add, tdata, be, wen);
            end
            step();
        end
        gnt = 1'b1;
        wait_done(40, to);
        repeat (3) step();
        tests++;
        if (to || hs_addr.size() - hb != 4 || wr_idx != 4) begin
            fails++;
            $display("FAIL wr_stall_done: got timeout=%b hs=%0d accepted=%0d, expected 0/4/4", to, hs_addr.size() - hb, wr_idx);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (hs_addr[hb+i] !== 32'h80 + 32'(4*i) || hs_data[hb+i] !== wr_data[i] || hs_wen[hb+i] !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_stall_word%0d: got add=%h data=%h wen=%b, expected %h/%h/0",
                             i, hs_addr[hb+i], hs_data[hb+i], hs_wen[hb+i], 32'h80 + 32'(4*i), wr_data[i]);
                end
            end
        end
        wr_data.delete();
        wr_be.delete();
        wdata_valid = 1'b0;
    endtask

    task automatic test_write();
        int hb;
        bit to;
        logic [31:0] exp_a [3];
        exp_a   = '{32'h40, 32'h44, 32'h48};
        wr_data = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        wr_be   = '{4'hF, 4'h3, 4'h8, 4'hF};
        load_stream(4);
        hb = hs_addr.size();
        gnt = 1'b1;
        issue(32'h40, 16'd3, 1'b1);
        wait_done(40, to);
        repeat (4) step();
        tests++;
        if (to || hs_addr.size() - hb != 3) begin
            fails++;
            $display("FAIL wr_count: got timeout=%b hs=%0d, expected 0/3", to, hs_addr.size() - hb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (hs_addr[hb+i] !== exp_a[i] || hs_data[hb+i] !== wr_data[i] || hs_be[hb+i] !== wr_be[i] || hs_wen[hb+i] !== 1'b0) begin
                    fails++;
                    $display("FAIL wr_word%0d: got add=%h data=%h be=%h wen=%b, expected %h/%h/%h/0",
                             i, hs_addr[hb+i], hs_data[hb+i], hs_be[hb+i], hs_wen[hb+i], exp_a[i], wr_data[i], wr_be[i]);
                end
            end
        end
        tests++;
        if (wr_idx != 3 || wdata_ready !== 1'b0) begin
            fails++;
            $display("FAIL wr_no_extra: got accepted=%0d ready=%b, expected 3/0", wr_idx, wdata_ready);
        end
        wr_data.delete();
        wr_be.delete();
        wdata_valid = 1'b0;
    endtask

    task automatic test_len0_and_wrap();
        int hb, rb, db;
        bit to;
        hb = hs_addr.size();
        db = done_cnt;
        gnt = 1'b1;
        rdata_ready = 1'b1;
        issue(32'h600, 16'd0, 1'b0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || req !== 1'b0) begin
            fails++;
            $display("FAIL len0_done: got done=%b busy=%b req=%b, expected 1/0/0", done, busy, req);
        end
        step();
        step();
        tests++;
        if (done !== 1'b0 || done_cnt - db != 1 || hs_addr.size() != hb) begin
            fails++;
            $display("FAIL len0_after: got done=%b pulses=%0d hs=%0d, expected 0/1/0", done, done_cnt - db, hs_addr.size() - hb);
        end
        hb = hs_addr.size();
        rb = rd_log.size();
        issue(32'hFFFF_FFFC, 16'd2, 1'b0);
        wait_done(40, to);
        tests++;
        if (to || hs_addr.size() - hb != 2) begin
            fails++;
            $display("FAIL wrap_count: got timeout=%b hs=%0d, expected 0/2", to, hs_addr.size() - hb);
        end else begin
            tests++;
            if (hs_addr[hb] !== 32'hFFFF_FFFC || hs_addr[hb+1] !== 32'h0) begin
                fails++;
                $display("FAIL wrap_addr: got %h,%h, expected fffffffc,00000000", hs_addr[hb], hs_addr[hb+1]);
            end
        end
        tests++;
        if (rd_log.size() - rb != 2 || rd_log[rb+1] !== mem_word(32'h0)) begin
            fails++;
            $display("FAIL wrap_rdata: got %0d words, expected 2 with last %h", rd_log.size() - rb, mem_word(32'h0));
        end
    endtask

    task automatic test_reset_midop();
        int db;
        gnt = 1'b1;
        rdata_ready = 1'b0;
        issue(32'h500, 16'd4, 1'b0);
        step();
        step();
        gnt = 1'b0;
        step();
        tests++;
        if (rdata_valid !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL midop_pre: got rvalid=%b busy=%b, expected 1/1", rdata_valid, busy);
        end
        db = done_cnt;
        rst_n = 1'b0;
        #1;
        tests++;
        if (req !== 1'b0 || busy !== 1'b0 || rdata_valid !== 1'b0 || cmd_ready !== 1'b1 || wen !== 1'b1 || add !== 32'h0 || done !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset: got req=%b busy=%b rvalid=%b ready=%b wen=%b add=%h done=%b, expected 0/0/0/1/1/0/0",
                     req, busy, rdata_valid, cmd_ready, wen, add, done);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        tests++;
        if (done_cnt != db || rdata_valid !== 1'b0) begin
            fails++;
            $display("FAIL midop_no_done: got pulses=%0d rvalid=%b, expected 0/0", done_cnt - db, rdata_valid);
        end
        test_read_basic(32'h100, "post_reset");
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        cmd_write   = 1'b0;
        wdata_valid = 1'b0;
        wdata       = '0;
        wbe         = '0;
        rdata_ready = 1'b0;
        gnt         = 1'b0;
        r_data      = '0;
        r_id        = 1'b0;

        test_reset();
        test_read_basic(32'h100, "read_basic");
        test_backpressure();
        test_gnt_stall();
        test_write();
        test_len0_and_wrap();
        test_reset_midop();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
